// File: rtl/voice_allocator.sv
// voice_allocator: assigns debounced key presses to a pool of oscillator voices, round-robin over keys.
// Optional VOICE_STEAL_EN: a press arriving at a full pool takes the oldest voice instead of waiting.
module voice_allocator #(
  parameter int NUM_KEYS   = 16,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 4,
  parameter int AGE_W      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_KEYS-1:0]               pb,
  output logic [NUM_VOICES-1:0]             voice_active,
  output logic [NUM_VOICES*KEY_W-1:0]       voice_key,
  output logic [NUM_VOICES-1:0]             voice_start,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_count,
  output logic                              drop_pulse
);
  localparam int CNT_W = $clog2(NUM_VOICES + 1);
  localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  logic [NUM_KEYS-1:0]   pb_q, pend_q, pend_d, cand;
  logic [KEY_W-1:0]      ptr_q, ptr_d, sel_k;
  logic [AGE_W-1:0]      age_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_d [NUM_VOICES];
  logic [KEY_W-1:0]      key_q [NUM_VOICES];
  logic [KEY_W-1:0]      key_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d, start_q, start_d, rel, live;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  drop_q, drop_d, found, free_found, serve;
  logic [VI_W-1:0]       free_v, tgt;
`ifdef VOICE_STEAL_EN
  logic [VI_W-1:0]       old_v;
`endif
  always_comb begin
    rel = '0;
    for (int v = 0; v < NUM_VOICES; v++) rel[v] = active_q[v] & ~pb_q[key_q[v]];
    live = active_q & ~rel;
    cand = pend_q & pb_q;
    found = 1'b0;
    sel_k = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!found && cand[(int'(ptr_q) + i) % NUM_KEYS]) begin
        found = 1'b1;
        sel_k = KEY_W'((int'(ptr_q) + i) % NUM_KEYS);
      end
    end
    free_found = 1'b0;
    free_v = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!free_found && !live[v]) begin
        free_found = 1'b1;
        free_v = VI_W'(v);
      end
    end
`ifdef VOICE_STEAL_EN
    // strict compare keeps the lowest index on equal ages
    old_v = '0;
    for (int v = 1; v < NUM_VOICES; v++) if (age_q[v] > age_q[old_v]) old_v = VI_W'(v);
    tgt   = free_found ? free_v : old_v;
    serve = found;
`else
    tgt   = free_v;
    serve = found & free_found;
`endif
    active_d = live;
    key_d    = key_q;
    age_d    = age_q;
    start_d  = '0;
    ptr_d    = ptr_q;
    pend_d   = (pend_q & pb_q) | (pb & ~pb_q);
    drop_d   = |(pend_q & ~pb_q);
    if (serve) begin
      active_d[tgt] = 1'b1;
      key_d[tgt]    = sel_k;
      start_d[tgt]  = 1'b1;
      pend_d[sel_k] = 1'b0;
      ptr_d         = KEY_W'((int'(sel_k) + 1) % NUM_KEYS);
      for (int v = 0; v < NUM_VOICES; v++)
        age_d[v] = (v == int'(tgt)) ? '0 :
                   (live[v] && age_q[v] != '1) ? age_q[v] + 1'b1 : age_q[v];
    end
    cnt_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) cnt_d = cnt_d + CNT_W'(active_d[v]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pb_q     <= '0;
      pend_q   <= '0;
      ptr_q    <= '0;
      age_q    <= '{default: '0};
      key_q    <= '{default: '0};
      active_q <= '0;
      start_q  <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      pb_q     <= pb;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      age_q    <= age_d;
      key_q    <= key_d;
      active_q <= active_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key
    assign voice_key[g*KEY_W +: KEY_W] = key_q[g];
  end
  assign voice_active = active_q;
  assign voice_start  = start_q;
  assign active_count = cnt_q;
  assign drop_pulse   = drop_q;
endmodule
